rv32_scoreboard_hazard_unit: RTL and testbench

- Parametrised scoreboard-based data-hazard unit in the decode stage. Supports variable-latency producers: ALU, load, and multi-cycle MUL/DIV/FPU.
- Tracks pending register writes per architectural register. Generates the issue stall and per-operand bypass-stage selects.
- Also detects WAW hazards, write-port (result-slot) conflicts, and CSR serialisation over a configurable depth.

---
 rtl/rv32_scoreboard_hazard_unit_if.sv | 33 +++
 rtl/rv32_scoreboard_hazard_unit.sv | 113 +++++++++++
 tb/tb_rv32_scoreboard_hazard_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rv32_scoreboard_hazard_unit_if.sv
// Decode-to-hazard-unit bundle: instruction operand/destination info in,
// issue stall and per-operand bypass selects out.
interface rv32_scoreboard_hazard_unit_if #(
  parameter int unsigned NUM_READ    = 3,
  parameter int unsigned MAX_LATENCY = 8,
  parameter int unsigned BYP_STAGES  = 2
);
  localparam int unsigned LAT_W  = $clog2(MAX_LATENCY + 1);
  localparam int unsigned BSEL_W = $clog2(BYP_STAGES + 1);

  logic                       issue_valid;
  logic [NUM_READ-1:0]        use_rs;
  logic [NUM_READ*5-1:0]      rs_id;
  logic [4:0]                 rd_id;
  logic                       rd_wb;
  logic [LAT_W-1:0]           rd_latency;
  logic                       is_csr;
  logic                       flush;
  logic                       stall;
  logic [NUM_READ*BSEL_W-1:0] bypass_rs;

  // Decode stage side
  modport master (
    output issue_valid, use_rs, rs_id, rd_id, rd_wb, rd_latency, is_csr, flush,
    input  stall, bypass_rs
  );

  // Hazard unit side
  modport slave (
    input  issue_valid, use_rs, rs_id, rd_id, rd_wb, rd_latency, is_csr, flush,
    output stall, bypass_rs
  );
endinterface

// File: rtl/rv32_scoreboard_hazard_unit.sv
// Scoreboard data-hazard unit for the decode stage. Each architectural
// register holds a countdown of cycles until its pending result has drained
// out of the bypass network; a result-slot occupancy vector guards the single
// result port; a small counter serialises CSR accesses.
module rv32_scoreboard_hazard_unit #(
  parameter int unsigned NUM_READ    = 3,
  parameter int unsigned MAX_LATENCY = 8,
  parameter int unsigned BYP_STAGES  = 2,
  parameter int unsigned CSR_DEPTH   = 2
) (
  input logic                       clk,
  input logic                       rst,
  rv32_scoreboard_hazard_unit_if.slave bus
);
  localparam int unsigned CNT_W  = $clog2(MAX_LATENCY + BYP_STAGES + 1);
  localparam int unsigned LAT_W  = $clog2(MAX_LATENCY + 1);
  localparam int unsigned BSEL_W = $clog2(BYP_STAGES + 1);
  localparam int unsigned CSR_W  = (CSR_DEPTH < 1) ? 1 : $clog2(CSR_DEPTH + 1);

  logic [CNT_W-1:0]         cnt_q [32];
  logic [MAX_LATENCY:1]     occ_q;
  logic [CSR_W-1:0]         csr_q;

  logic [LAT_W-1:0]         lat_eff;
  logic [CNT_W-1:0]         rd_target;
  logic                     rd_act;
  logic                     raw_hz;
  logic                     waw_hz;
  logic                     slot_hz;
  logic                     csr_hz;
  logic                     fire;
  logic [NUM_READ*BSEL_W-1:0] bypass_d;

  // Latency 0 behaves as 1; values above MAX_LATENCY are clamped so the
  // occupancy index stays in range.
  always_comb begin
    lat_eff = bus.rd_latency;
    if (bus.rd_latency == '0) begin
      lat_eff = LAT_W'(1);
    end else if (bus.rd_latency > LAT_W'(MAX_LATENCY)) begin
      lat_eff = LAT_W'(MAX_LATENCY);
    end
  end

  assign rd_target = CNT_W'(lat_eff) + CNT_W'(BYP_STAGES - 1);
  assign rd_act    = bus.rd_wb && (bus.rd_id != 5'd0);

  // Destination-side hazards: an older write outliving the new one, or the
  // new producer's result-port cycle already being claimed.
  always_comb begin
    waw_hz  = rd_act && (cnt_q[bus.rd_id] > rd_target);
    slot_hz = rd_act && (lat_eff >= LAT_W'(2)) && occ_q[lat_eff];
    csr_hz  = bus.is_csr && (csr_q != '0);
  end

  // Source-side: RAW stall while the producer has not reached stage 1,
  // otherwise pick the bypass stage that currently holds the value.
  always_comb begin
    logic [4:0]       rs;
    logic [CNT_W-1:0] c;
    raw_hz   = 1'b0;
    bypass_d = '0;
    rs       = '0;
    c        = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      rs = bus.rs_id[i*5 +: 5];
      c  = cnt_q[rs];
      if (bus.use_rs[i] && (rs != 5'd0)) begin
        if (c > CNT_W'(BYP_STAGES)) begin
          raw_hz = 1'b1;
        end else if (c != '0) begin
          bypass_d[i*BSEL_W +: BSEL_W] =
            BSEL_W'(CNT_W'(BYP_STAGES) - c + CNT_W'(1));
        end
      end
    end
  end

  assign bus.stall     = bus.issue_valid && (raw_hz || waw_hz || slot_hz || csr_hz);
  assign bus.bypass_rs = bypass_d;
  assign fire          = bus.issue_valid && !bus.stall && !bus.flush;

  // Scoreboard state: age every entry, then record the issuing instruction.
  // Flush and reset both wipe everything and suppress the same-cycle issue.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int unsigned r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      occ_q <= '0;
      csr_q <= '0;
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - CNT_W'(1);
        end
      end
      occ_q <= {1'b0, occ_q[MAX_LATENCY:2]};
      if (csr_q != '0) begin
        csr_q <= csr_q - CSR_W'(1);
      end
      if (fire && rd_act) begin
        cnt_q[bus.rd_id] <= rd_target;
        if (lat_eff >= LAT_W'(2)) begin
          occ_q[lat_eff - LAT_W'(1)] <= 1'b1;
        end
      end
      if (fire && bus.is_csr) begin
        csr_q <= CSR_W'(CSR_DEPTH);
      end
    end
  end
endmodule

// File: tb/tb_rv32_scoreboard_hazard_unit.sv
// Directed bench for the scoreboard hazard unit: each step drives one decode
// instruction, queues the expected stall/bypass, and checks at the negedge.
module tb_rv32_scoreboard_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rv32_scoreboard_hazard_unit_if #(
    .NUM_READ(3), .MAX_LATENCY(8), .BYP_STAGES(2)
  ) bus ();

  rv32_scoreboard_hazard_unit #(
    .NUM_READ(3), .MAX_LATENCY(8), .BYP_STAGES(2), .CSR_DEPTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string      tag;
    logic       stall;
    logic [5:0] byp;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  function automatic logic [5:0] bp(input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] c);
    return {c, b, a};
  endfunction

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    total++;
    assert (bus.stall === e.stall) passed++;
    else $error("FAIL %s stall: observed %b expected %b", e.tag, bus.stall, e.stall);
    if (!e.stall) begin
      total++;
      assert (bus.bypass_rs === e.byp) passed++;
      else $error("FAIL %s bypass: observed %b expected %b", e.tag, bus.bypass_rs, e.byp);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic fl,
                      input logic [2:0] u, input logic [4:0] r0,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic wb,
                      input logic [3:0] lat, input logic csr,
                      input logic xs, input logic [5:0] xb);
    exp_t e;
    bus.issue_valid = v;
    bus.flush       = fl;
    bus.use_rs      = u;
    bus.rs_id       = {r2, r1, r0};
    bus.rd_id       = rd;
    bus.rd_wb       = wb;
    bus.rd_latency  = lat;
    bus.is_csr      = csr;
    e.tag = tag; e.stall = xs; e.byp = xb;
    sb.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 4'd1, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic flush_idle(input string tag);
    step(tag, 1'b0, 1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 4'd1, 1'b0, 1'b0, 6'd0);
  endtask

  initial begin
    bus.issue_valid = 1'b0; bus.flush = 1'b0; bus.use_rs = '0; bus.rs_id = '0;
    bus.rd_id = '0; bus.rd_wb = 1'b0; bus.rd_latency = '0; bus.is_csr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // out of reset nothing is pending
    step("reset_out", 1, 0, 3'b111, 5'd1, 5'd2, 5'd3, 5'd4, 0, 4'd1, 0, 0, 6'd0);

    // ALU chain, L=1
    step("alu_prod", 1, 0, 3'b011, 5'd1, 5'd2, 5'd0, 5'd5, 1, 4'd1, 0, 0, 6'd0);
    step("alu_byp1", 1, 0, 3'b001, 5'd5, 5'd0, 5'd0, 5'd6, 1, 4'd1, 0, 0, bp(2'd1, 2'd0, 2'd0));
    step("alu_byp2", 1, 0, 3'b011, 5'd5, 5'd6, 5'd0, 5'd0, 0, 4'd1, 0, 0, bp(2'd2, 2'd1, 2'd0));
    step("alu_rf",   1, 0, 3'b011, 5'd5, 5'd6, 5'd0, 5'd0, 0, 4'd1, 0, 0, bp(2'd0, 2'd2, 2'd0));
    step("alu_done", 1, 0, 3'b011, 5'd5, 5'd6, 5'd0, 5'd0, 0, 4'd1, 0, 0, 6'd0);

    // load-use, L=2
    step("lw_prod",      1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd7, 1, 4'd2, 0, 0, 6'd0);
    step("lw_use_stall", 1, 0, 3'b001, 5'd7, 5'd0, 5'd0, 5'd0, 0, 4'd1, 0, 1, 6'd0);
    step("lw_use_byp1",  1, 0, 3'b001, 5'd7, 5'd0, 5'd0, 5'd0, 0, 4'd1, 0, 0, bp(2'd1, 2'd0, 2'd0));
    step("lw2_prod",     1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd7, 1, 4'd2, 0, 0, 6'd0);
    step("lw_nouse",     1, 0, 3'b000, 5'd7, 5'd0, 5'd0, 5'd0, 0, 4'd1, 0, 0, 6'd0);
    step("rs_zero",      1, 0, 3'b001, 5'd0, 5'd0, 5'd0, 5'd0, 0, 4'd1, 0, 0, 6'd0);
    flush_idle("flush_a");

    // WAW against a long-latency producer: cnt[x8] is 9..3 over t+1..t+7
    step("div_waw_prod", 1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd8, 1, 4'd8, 0, 0, 6'd0);
    for (int k = 1; k <= 7; k++)
      step("waw_stall", 1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd8, 1, 4'd1, 0, 1, 6'd0);
    step("waw_issue", 1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd8, 1, 4'd1, 0, 0, 6'd0);
    flush_idle("flush_b");

    // RAW against a long-latency producer
    step("div_raw_prod", 1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd8, 1, 4'd8, 0, 0, 6'd0);
    for (int k = 1; k <= 7; k++)
      step("raw_long_stall", 1, 0, 3'b001, 5'd8, 5'd0, 5'd0, 5'd0, 0, 4'd1, 0, 1, 6'd0);
    step("raw_long_byp1", 1, 0, 3'b001, 5'd8, 5'd0, 5'd0, 5'd0, 0, 4'd1, 0, 0, bp(2'd1, 2'd0, 2'd0));
    flush_idle("flush_c");

    // result-slot conflict
    step("div4_prod",    1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd9,  1, 4'd4, 0, 0, 6'd0);
    idle("slot_gap");
    step("slot_stall",   1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd10, 1, 4'd2, 0, 1, 6'd0);
    step("slot_issue",   1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd10, 1, 4'd2, 0, 0, 6'd0);
    idle("slot_gap2");
    step("slot_results", 1, 0, 3'b011, 5'd9, 5'd10, 5'd0, 5'd0, 0, 4'd1, 0, 0, bp(2'd2, 2'd1, 2'd0));
    flush_idle("flush_d");

    // CSR serialisation
    step("csr_a",        1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 0, 4'd1, 1, 0, 6'd0);
    step("csr_b_stall1", 1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 0, 4'd1, 1, 1, 6'd0);
    step("csr_b_stall2", 1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 0, 4'd1, 1, 1, 6'd0);
    step("csr_b_issue",  1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 0, 4'd1, 1, 0, 6'd0);
    step("noncsr_ok",    1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 0, 4'd1, 0, 0, 6'd0);
    step("csr_c_stall",  1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 0, 4'd1, 1, 1, 6'd0);
    flush_idle("flush_e");

    // x0 never tracked: no RAW, no WAW, no slot reservation
    step("x0_write", 1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0,  1, 4'd3, 0, 0, 6'd0);
    step("x0_read",  1, 0, 3'b111, 5'd0, 5'd0, 5'd0, 5'd15, 1, 4'd2, 0, 0, 6'd0);
    flush_idle("flush_f");

    // flush: stall still computed in the flush cycle, state gone afterwards
    step("fl_div",         1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd8, 1, 4'd8, 0, 0, 6'd0);
    step("fl_cycle_stall", 1, 1, 3'b001, 5'd8, 5'd0, 5'd0, 5'd0, 0, 4'd1, 0, 1, 6'd0);
    step("fl_after",       1, 0, 3'b001, 5'd8, 5'd0, 5'd0, 5'd0, 0, 4'd1, 0, 0, 6'd0);
    step("fl_fire_dom",    1, 1, 3'b000, 5'd0, 5'd0, 5'd0, 5'd11, 1, 4'd3, 0, 0, 6'd0);
    step("fl_fire_none",   1, 0, 3'b001, 5'd11, 5'd0, 5'd0, 5'd13, 1, 4'd2, 0, 0, 6'd0);

    // reset mid-operation
    step("rst_div", 1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd8, 1, 4'd8, 0, 0, 6'd0);
    rst = 1'b1;
    idle("rst_hold");
    rst = 1'b0;
    step("rst_after", 1, 0, 3'b001, 5'd8, 5'd0, 5'd0, 5'd0, 0, 4'd1, 0, 0, 6'd0);

    // latency 0 behaves as ALU latency 1
    step("lat0_prod", 1, 0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd14, 1, 4'd0, 0, 0, 6'd0);
    step("lat0_byp1", 1, 0, 3'b001, 5'd14, 5'd0, 5'd0, 5'd0, 0, 4'd1, 0, 0, bp(2'd1, 2'd0, 2'd0));

    total++;
    assert (sb.size() == 0) passed++;
    else $error("FAIL sb_drain: observed %0d expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
